// File: rtl/c3lib_ckg_pkg.sv
// Shared types for the c3lib idle-detect clock gaters.
package c3lib_ckg_pkg;

   typedef enum logic [1:0] {
      CKG_RUN      = 2'd0,
      CKG_IDLE_CNT = 2'd1,
      CKG_GATED    = 2'd2
   } ckg_state_t;

   localparam ckg_state_t CKG_STATE_RST = CKG_RUN;

endpackage

// File: rtl/c3lib_ckg_idle_ch.sv
// One gated-clock channel: idle FSM, idle counter, enable flop, low-transparent latch gate.
// Optional saturating wake counter when C3LIB_CKG_STATS_EN is defined.
module c3lib_ckg_idle_ch
   import c3lib_ckg_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = 8
`ifdef C3LIB_CKG_STATS_EN
   , parameter int unsigned STAT_W = 16
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic tst_en,
   input  logic act,
   output logic gated_clk,
   output logic ch_gated,
   output logic gated_nxt_c
`ifdef C3LIB_CKG_STATS_EN
   , output logic [STAT_W-1:0] wake_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(IDLE_CYCLES + 1);

   ckg_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             en_q, en_d;
   logic             gated_q, gated_d;
   logic             latch_q, latch_d;

   // Next-state and idle-count logic; activity always wins over the gating condition
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CKG_RUN: begin
            if (!act) begin
               state_d = CKG_IDLE_CNT;
               cnt_d   = CNT_W'(1);
            end
         end
         CKG_IDLE_CNT: begin
            if (act) begin
               state_d = CKG_RUN;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(IDLE_CYCLES)) begin
               state_d = CKG_GATED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CKG_GATED: begin
            if (act) begin
               state_d = CKG_RUN;
            end
         end
         default: begin
            state_d = CKG_STATE_RST;
            cnt_d   = '0;
         end
      endcase
      en_d    = (state_d != CKG_GATED);
      gated_d = (state_d == CKG_GATED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CKG_STATE_RST;
         cnt_q   <= '0;
         en_q    <= 1'b1;
         gated_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         gated_q <= gated_d;
      end
   end

   // Enable is only allowed to change while clk is low, so the AND never chops a pulse
   assign latch_d = en_q | tst_en;

   always_latch begin
      if (!clk) begin
         latch_q = latch_d;
      end
   end

   assign gated_clk   = clk & latch_q;
   assign ch_gated    = gated_q;
   assign gated_nxt_c = gated_d;

`ifdef C3LIB_CKG_STATS_EN
   logic [STAT_W-1:0] wake_q, wake_d;

   always_comb begin
      wake_d = wake_q;
      if ((state_q == CKG_GATED) && (state_d == CKG_RUN) && (wake_q != {STAT_W{1'b1}})) begin
         wake_d = wake_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wake_q <= '0;
      end else begin
         wake_q <= wake_d;
      end
   end

   assign wake_cnt = wake_q;
`endif

endmodule

// File: rtl/c3lib_ckg_idle_nch.sv
// NUM_CH independent idle-detect clock gaters sharing one clock root.
// Define C3LIB_CKG_STATS_EN to add per-channel saturating wake counters on wake_cnt.
module c3lib_ckg_idle_nch
   import c3lib_ckg_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned IDLE_CYCLES = 8,
   parameter int unsigned STAT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tst_en,
   input  logic [NUM_CH-1:0] ch_busy,
   input  logic [NUM_CH-1:0] ch_force_on,
   output logic [NUM_CH-1:0] gated_clk,
   output logic [NUM_CH-1:0] ch_gated,
   output logic              all_gated
`ifdef C3LIB_CKG_STATS_EN
   , output logic [NUM_CH*STAT_W-1:0] wake_cnt
`endif
);

   if ((NUM_CH < 1) || (IDLE_CYCLES < 1) || (STAT_W < 1)) begin : g_param_chk
      $error("c3lib_ckg_idle_nch: NUM_CH, IDLE_CYCLES and STAT_W must all be >= 1");
   end

   logic [NUM_CH-1:0] act_c;
   logic [NUM_CH-1:0] gated_nxt_c;
   logic              all_gated_q, all_gated_d;

   assign act_c = ch_busy | ch_force_on;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      c3lib_ckg_idle_ch #(
         .IDLE_CYCLES (IDLE_CYCLES)
`ifdef C3LIB_CKG_STATS_EN
         , .STAT_W    (STAT_W)
`endif
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .tst_en      (tst_en),
         .act         (act_c[i]),
         .gated_clk   (gated_clk[i]),
         .ch_gated    (ch_gated[i]),
         .gated_nxt_c (gated_nxt_c[i])
`ifdef C3LIB_CKG_STATS_EN
         , .wake_cnt  (wake_cnt[i*STAT_W +: STAT_W])
`endif
      );
   end

   // Built from next-state so it updates on the same edge as ch_gated
   always_comb begin
      all_gated_d = &gated_nxt_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         all_gated_q <= 1'b0;
      end else begin
         all_gated_q <= all_gated_d;
      end
   end

   assign all_gated = all_gated_q;

endmodule

// File: tb/tb_c3lib_ckg_idle_nch.sv
// Directed, table-driven bench for c3lib_ckg_idle_nch (NUM_CH=4, IDLE_CYCLES=8).
module tb_c3lib_ckg_idle_nch;

   localparam int unsigned NCH  = 4;
   localparam int unsigned IC   = 8;
   localparam int unsigned TSW  = 2;

   logic           clk;
   logic           rst;
   logic           tst_en;
   logic [NCH-1:0] ch_busy;
   logic [NCH-1:0] ch_force_on;
   logic [NCH-1:0] gated_clk;
   logic [NCH-1:0] ch_gated;
   logic           all_gated;
`ifdef C3LIB_CKG_STATS_EN
   logic [NCH*TSW-1:0] wake_cnt;
`endif

   c3lib_ckg_idle_nch #(
      .NUM_CH      (NCH),
      .IDLE_CYCLES (IC),
      .STAT_W      (TSW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tst_en      (tst_en),
      .ch_busy     (ch_busy),
      .ch_force_on (ch_force_on),
      .gated_clk   (gated_clk),
      .ch_gated    (ch_gated),
      .all_gated   (all_gated)
`ifdef C3LIB_CKG_STATS_EN
      , .wake_cnt  (wake_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [3:0] busy;
      logic [3:0] frc;
      logic       tst;
      logic [3:0] del;
      logic [3:0] gated;
      logic       all;
   } vec_t;

   vec_t vq[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   glitches = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] b, input logic [3:0] f, input logic t,
                      input logic [3:0] d, input logic [3:0] g, input logic a);
      vq.push_back('{b, f, t, d, g, a});
   endtask

   // One clock: report which channels got a pulse, and flag any partial or low-phase pulse
   task automatic tick(output logic [3:0] del);
      @(posedge clk);
      #1;
      del = gated_clk;
      #3;
      if (gated_clk !== del) glitches++;
      @(negedge clk);
      #1;
      if (gated_clk !== 4'b0000) glitches++;
   endtask

   task automatic step_chk(input string name, input logic [3:0] d, input logic [3:0] g, input logic a);
      logic [3:0] got;
      tick(got);
      chk({name, " del"}, 32'(got), 32'(d));
      chk({name, " ch_gated"}, 32'(ch_gated), 32'(g));
      chk({name, " all_gated"}, 32'(all_gated), 32'(a));
   endtask

   // From RUN with all inputs idle: IC delivered edges, one gating edge (still delivered), then silence
   task automatic run_regate(input string name);
      for (int i = 0; i < IC; i++) step_chk($sformatf("%s idle%0d", name, i), 4'hF, 4'h0, 1'b0);
      step_chk({name, " gate"}, 4'hF, 4'hF, 1'b1);
      step_chk({name, " off"}, 4'h0, 4'hF, 1'b1);
   endtask

   initial begin
      logic [3:0] d;

      rst = 1'b1;
      tst_en = 1'b0;
      ch_busy = '0;
      ch_force_on = '0;

      // Test 1: reset release with everything idle
      for (int i = 0; i < IC; i++) add(4'h0, 4'h0, 1'b0, 4'hF, 4'h0, 1'b0);
      add(4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 1'b1);
      add(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 1'b1);
      // Test 2: one-cycle busy pulse wakes ch0 one edge later, then regates
      add(4'h1, 4'h0, 1'b0, 4'h0, 4'hE, 1'b0);
      for (int i = 0; i < IC; i++) add(4'h0, 4'h0, 1'b0, 4'h1, 4'hE, 1'b0);
      add(4'h0, 4'h0, 1'b0, 4'h1, 4'hF, 1'b1);
      add(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 1'b1);
      // Test 3: ch1 busy returns exactly on the gating edge
      add(4'h2, 4'h0, 1'b0, 4'h0, 4'hD, 1'b0);
      add(4'h2, 4'h0, 1'b0, 4'h2, 4'hD, 1'b0);
      for (int i = 0; i < IC; i++) add(4'h0, 4'h0, 1'b0, 4'h2, 4'hD, 1'b0);
      add(4'h2, 4'h0, 1'b0, 4'h2, 4'hD, 1'b0);
      for (int i = 0; i < IC; i++) add(4'h0, 4'h0, 1'b0, 4'h2, 4'hD, 1'b0);
      add(4'h0, 4'h0, 1'b0, 4'h2, 4'hF, 1'b1);
      add(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 1'b1);
      // force_on behaves like busy on ch3
      add(4'h0, 4'h8, 1'b0, 4'h0, 4'h7, 1'b0);
      add(4'h0, 4'h8, 1'b0, 4'h8, 4'h7, 1'b0);
      for (int i = 0; i < IC; i++) add(4'h0, 4'h0, 1'b0, 4'h8, 4'h7, 1'b0);
      add(4'h0, 4'h0, 1'b0, 4'h8, 4'hF, 1'b1);
      add(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 1'b1);
      // Test 4: tst_en overrides the gate only
      add(4'h0, 4'h0, 1'b1, 4'hF, 4'hF, 1'b1);
      add(4'h0, 4'h0, 1'b1, 4'hF, 4'hF, 1'b1);
      add(4'h0, 4'h0, 1'b0, 4'h0, 4'hF, 1'b1);

      repeat (3) @(negedge clk);
      #1;
      chk("rst ch_gated", 32'(ch_gated), 32'h0);
      chk("rst all_gated", 32'(all_gated), 32'h0);
      rst = 1'b0;
      chk("post-rst ch_gated", 32'(ch_gated), 32'h0);

      for (int i = 0; i < vq.size(); i++) begin
         ch_busy     = vq[i].busy;
         ch_force_on = vq[i].frc;
         tst_en      = vq[i].tst;
         step_chk($sformatf("v%0d", i), vq[i].del, vq[i].gated, vq[i].all);
      end

      // tst_en toggled while clk is high must not cut or create a pulse
      @(posedge clk);
      #2 tst_en = 1'b1;
      #2 chk("tst mid-high rise", 32'(gated_clk), 32'h0);
      @(negedge clk);
      #1;
      tick(d);
      chk("tst full pulse", 32'(d), 32'hF);
      @(posedge clk);
      #2 tst_en = 1'b0;
      #2 chk("tst mid-high fall", 32'(gated_clk), 32'hF);
      @(negedge clk);
      #1;
      tick(d);
      chk("tst off", 32'(d), 32'h0);

      // Test 5a: async reset from GATED
      rst = 1'b1;
      #1;
      chk("rst async ch_gated", 32'(ch_gated), 32'h0);
      chk("rst async all_gated", 32'(all_gated), 32'h0);
      tick(d);
      chk("rst clk resumes", 32'(d), 32'hF);
      rst = 1'b0;
      run_regate("rstg");

      // Test 5b: reset mid idle count (cnt=5), full count restarts
      ch_busy = 4'hF;
      step_chk("wake all", 4'h0, 4'h0, 1'b0);
      ch_busy = 4'h0;
      for (int i = 0; i < 5; i++) step_chk($sformatf("cnt%0d", i + 1), 4'hF, 4'h0, 1'b0);
      rst = 1'b1;
      tick(d);
      chk("rst mid cnt del", 32'(d), 32'hF);
      chk("rst mid cnt ch_gated", 32'(ch_gated), 32'h0);
      rst = 1'b0;
      run_regate("rstc");

`ifdef C3LIB_CKG_STATS_EN
      // Test 6: five wakes on ch2 saturate a 2-bit counter
      chk("wake_cnt clear", 32'(wake_cnt), 32'h0);
      for (int w = 0; w < 5; w++) begin
         ch_busy = 4'h4;
         step_chk($sformatf("st%0d wake", w), 4'h0, 4'hB, 1'b0);
         ch_busy = 4'h0;
         for (int i = 0; i < IC; i++) step_chk($sformatf("st%0d idle%0d", w, i), 4'h4, 4'hB, 1'b0);
         step_chk($sformatf("st%0d gate", w), 4'h4, 4'hF, 1'b1);
      end
      chk("wake_cnt sat", 32'(wake_cnt), 32'h30);
`endif

      chk("glitch-free pulses", 32'(glitches), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
